// File: rtl/tl_pkg.sv
// Shared TL-UL definitions: channel A/D opcodes, transfer sizes and the
// responder state encoding. The host-side channel D receiver imports the
// same opcode enums.
package tl_pkg;

  // Channel A request opcodes
  typedef enum logic [2:0] {
    A_PUT_FULL_DATA    = 3'd0,
    A_PUT_PARTIAL_DATA = 3'd1,
    A_GET              = 3'd4
  } a_opcode_e;

  // Channel D response opcodes
  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } d_opcode_e;

  // Transfer size, log2 of the byte count
  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } tl_size_e;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } resp_state_e;

  localparam int unsigned LANES = 4;

  // Response opcode follows the request class: only a Get carries data.
  // Put and unknown opcodes are answered with AccessAck.
  function automatic d_opcode_e d_opcode_for(input logic [2:0] a_op);
    d_opcode_e op;
    op = (a_op == A_GET) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
    return op;
  endfunction

endpackage

// File: rtl/tl_lane_mask.sv
// Byte-lane mask and natural-alignment check for a TL-UL access, derived
// from the transfer size and the low two address bits. Purely combinational.
import tl_pkg::*;

module tl_lane_mask (
  input  logic [1:0] size,
  input  logic [1:0] addr,
  output logic [3:0] mask,
  output logic       aligned
);

  // Decode size/offset into the lanes touched and whether the offset is legal
  always_comb begin
    mask    = 4'b0000;
    aligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        mask    = 4'b0001 << addr;
        aligned = 1'b1;
      end
      SZ_HALF: begin
        mask    = 4'b0011 << addr;
        aligned = ~addr[0];
      end
      SZ_WORD: begin
        mask    = 4'b1111;
        aligned = (addr == 2'b00);
      end
      default: begin
        // size 3 is never legal; no lanes
        mask    = 4'b0000;
        aligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/tl_ul_responder.sv
// Device-side TL-UL responder. Accepts one channel A request at a time,
// issues a single-cycle access to a word-wide synchronous memory and holds
// the single channel D response in registers until the host takes it.
import tl_pkg::*;

module tl_ul_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // channel A
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [2:0]        a_opcode_i,
  input  logic [1:0]        a_size_i,
  input  logic [ADDR_W-1:0] a_address_i,
  input  logic [3:0]        a_mask_i,
  input  logic [DATA_W-1:0] a_data_i,
  // channel D
  output logic              d_valid_o,
  input  logic              d_ready_i,
  output logic [2:0]        d_opcode_o,
  output logic [1:0]        d_size_o,
  output logic [DATA_W-1:0] d_data_o,
  output logic              d_error_o,
  // memory port
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_wmask_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  resp_state_e       state_reg;
  logic [2:0]        d_opcode_reg;
  logic [1:0]        d_size_reg;
  logic [DATA_W-1:0] d_data_reg;
  logic              d_error_reg;
  logic [3:0]        rd_mask_reg;

  logic [3:0]        lane_mask;
  logic              lane_aligned;
  logic              is_put_full;
  logic              is_put_partial;
  logic              is_get;
  logic              is_put;
  logic              opcode_ok;
  logic              partial_mask_ok;
  logic              legal;
  logic              accept;
  logic [DATA_W-1:0] rdata_masked;

  tl_lane_mask u_lane_mask (
    .size    (a_size_i),
    .addr    (a_address_i[1:0]),
    .mask    (lane_mask),
    .aligned (lane_aligned)
  );

  // Request classification and legality, evaluated in the accept cycle
  always_comb begin
    is_put_full     = (a_opcode_i == A_PUT_FULL_DATA);
    is_put_partial  = (a_opcode_i == A_PUT_PARTIAL_DATA);
    is_get          = (a_opcode_i == A_GET);
    is_put          = is_put_full | is_put_partial;
    opcode_ok       = is_put | is_get;
    // A partial write must enable at least one byte and stay inside the
    // lanes implied by size and offset.
    partial_mask_ok = (a_mask_i != 4'b0000) && ((a_mask_i & ~lane_mask) == 4'b0000);
    legal           = lane_aligned && opcode_ok && (!is_put_partial || partial_mask_ok);
  end

  // Ready only in IDLE, and held low while reset is asserted
  assign a_ready_o = (state_reg == ST_IDLE) && !rst_i;
  assign accept    = a_valid_i && a_ready_o;

  // The memory strobe exists only in the accept cycle of a legal request
  always_comb begin
    mem_req_o   = accept && legal;
    mem_we_o    = mem_req_o && is_put;
    mem_wmask_o = 4'b0000;
    if (mem_we_o) begin
      mem_wmask_o = is_put_partial ? a_mask_i : lane_mask;
    end
  end

  assign mem_addr_o  = {a_address_i[ADDR_W-1:2], 2'b00};
  assign mem_wdata_o = a_data_i;

  // Read data keeps its lane position; bytes outside the access are zeroed
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_rd_lane
      assign rdata_masked[gi*8 +: 8] = rd_mask_reg[gi] ? mem_rdata_i[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  // Responder FSM with registered channel D fields
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      d_opcode_reg <= 3'd0;
      d_size_reg   <= 2'd0;
      d_data_reg   <= '0;
      d_error_reg  <= 1'b0;
      rd_mask_reg  <= 4'b0000;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            d_opcode_reg <= d_opcode_for(a_opcode_i);
            d_size_reg   <= a_size_i;
            d_data_reg   <= '0;
            d_error_reg  <= ~legal;
            rd_mask_reg  <= lane_mask;
            state_reg    <= (legal && is_get) ? ST_RD_WAIT : ST_RESP;
          end
        end
        ST_RD_WAIT: begin
          d_data_reg <= rdata_masked;
          state_reg  <= ST_RESP;
        end
        ST_RESP: begin
          if (d_ready_i) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign d_valid_o  = (state_reg == ST_RESP);
  assign d_opcode_o = d_opcode_reg;
  assign d_size_o   = d_size_reg;
  assign d_data_o   = d_data_reg;
  assign d_error_o  = d_error_reg;

endmodule
